alu_bist_ctrl: RTL and testbench

//  Built-in self-test controller for the basic 4-bit ALU: the driving end of the ALU operand interface.
//  On start it sweeps every {a,b,sel} combination into the ALU, samples y after a settle window and

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_ref_model.sv | 35 +++
 rtl/alu_bist_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_bist_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode map and BIST FSM encodings shared by the 4-bit ALU, its golden model and the BIST controller.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU function: (a, b, sel) -> y, result one bit wider than the operands.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int A_W   = 4,
    parameter int SEL_W = 3
) (
    input  logic [A_W-1:0]   a_i,
    input  logic [A_W-1:0]   b_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [A_W:0]     y_o
);

    logic [A_W:0] a_ext;
    logic [A_W:0] b_ext;

    assign a_ext = {1'b0, a_i};
    assign b_ext = {1'b0, b_i};

    always_comb begin
        y_o = '0;
        case (sel_i)
            SEL_W'(OP_ADD): y_o = a_ext + b_ext;
            SEL_W'(OP_SUB): y_o = a_ext - b_ext;
            SEL_W'(OP_AND): y_o = a_ext & b_ext;
            SEL_W'(OP_OR):  y_o = a_ext | b_ext;
            SEL_W'(OP_XOR): y_o = a_ext ^ b_ext;
            SEL_W'(OP_NOT): y_o = {1'b0, ~a_i};
            SEL_W'(OP_SHL): y_o = {a_i, 1'b0};
            SEL_W'(OP_SHR): y_o = {1'b0, a_i >> 1};
            default:        y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU built-in self-test controller: sweeps every {a,b,sel} vector, samples y after a settle
// window and checks it against the golden model, reporting pass/fail, error count and first failure.
module alu_bist_ctrl
    import alu_pkg::*;
#(
    parameter int A_W           = 4,
    parameter int SEL_W         = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_in,
    output logic [A_W-1:0]           a_out,
    output logic [A_W-1:0]           b_out,
    output logic [SEL_W-1:0]         sel_out,
    input  logic [A_W:0]             y_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     pass_out,
    output logic [ERR_W-1:0]         err_count_out,
    output logic [2*A_W+SEL_W-1:0]   fail_vec_out
);

    localparam int VEC_W = 2*A_W + SEL_W;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    bist_state_e      state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] fail_q, fail_d;

    logic             settle_done;
    logic             last_vec;
    logic             mismatch;
    logic [A_W:0]     y_golden;

    // vec_q is {a, b, sel}: sel is the least significant field so it sweeps fastest.
    assign a_out   = vec_q[VEC_W-1 -: A_W];
    assign b_out   = vec_q[SEL_W +: A_W];
    assign sel_out = vec_q[SEL_W-1:0];

    alu_ref_model #(
        .A_W   (A_W),
        .SEL_W (SEL_W)
    ) u_ref (
        .a_i   (a_out),
        .b_i   (b_out),
        .sel_i (sel_out),
        .y_o   (y_golden)
    );

    assign settle_done = (settle_q == SET_W'(SETTLE_CYCLES - 1));
    assign last_vec    = &vec_q;
    assign mismatch    = (y_in != y_golden);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_DONE:  if (start_in) state_d = ST_APPLY;
            ST_APPLY: if (settle_done) state_d = ST_CHECK;
            ST_CHECK: state_d = last_vec ? ST_DONE : ST_APPLY;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;
        case (state_q)
            ST_IDLE,
            ST_DONE: begin
                if (start_in) begin
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    fail_d   = '0;
                end
            end
            ST_APPLY: settle_d = settle_done ? '0 : settle_q + SET_W'(1);
            ST_CHECK: begin
                vec_d = vec_q + VEC_W'(1);
                if (mismatch) begin
                    if (!(&err_q)) err_d = err_q + ERR_W'(1);
                    // A non-zero count means an earlier mismatch already owns fail_q.
                    if (err_q == '0) fail_d = vec_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_out      = (state_q == ST_APPLY) || (state_q == ST_CHECK);
        done_out      = (state_q == ST_DONE);
        pass_out      = done_out && (err_q == '0);
        err_count_out = err_q;
        fail_vec_out  = fail_q;
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: good, faulty and stuck ALUs, settle window, reset and restart.
module tb_alu_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start_v = 3'b000;
    logic [2:0] busy_v, done_v, pass_v;
    logic [2:0][31:0] err_v;
    logic [2:0][10:0] fvec_v;

    int fault0 = 0;
    int passed = 0;
    int total  = 0;

    // 0 = good ALU, 1 = SUB returns a+b, 2 = output stuck at 0.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] sel, input int fault);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (sel)
            3'd0: r = ia + ib;
            3'd1: r = (ia + 32 - ib) % 32;
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 15 - ia;
            3'd6: r = ia * 2;
            default: r = ia / 2;
        endcase
        if (fault == 1 && sel == 3'd1) r = ia + ib;
        if (fault == 2) r = 0;
        return 5'(r);
    endfunction

    logic [3:0] a0, b0, a1, b1, a2, b2;
    logic [2:0] s0, s1, s2;
    logic [4:0] y0, y1, y2;
    logic [11:0] e0, e1;
    logic [3:0]  e2;

    assign y0 = alu_fn(a0, b0, s0, fault0);
    assign y1 = alu_fn(a1, b1, s1, 0);
    assign y2 = alu_fn(a2, b2, s2, 2);
    assign err_v[0] = {20'd0, e0};
    assign err_v[1] = {20'd0, e1};
    assign err_v[2] = {28'd0, e2};

    alu_bist_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start_in(start_v[0]),
        .a_out(a0), .b_out(b0), .sel_out(s0), .y_in(y0),
        .busy_out(busy_v[0]), .done_out(done_v[0]), .pass_out(pass_v[0]),
        .err_count_out(e0), .fail_vec_out(fvec_v[0])
    );

    alu_bist_ctrl #(.SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .start_in(start_v[1]),
        .a_out(a1), .b_out(b1), .sel_out(s1), .y_in(y1),
        .busy_out(busy_v[1]), .done_out(done_v[1]), .pass_out(pass_v[1]),
        .err_count_out(e1), .fail_vec_out(fvec_v[1])
    );

    alu_bist_ctrl #(.ERR_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .start_in(start_v[2]),
        .a_out(a2), .b_out(b2), .sel_out(s2), .y_in(y2),
        .busy_out(busy_v[2]), .done_out(done_v[2]), .pass_out(pass_v[2]),
        .err_count_out(e2), .fail_vec_out(fvec_v[2])
    );

    // Operand hold-time monitor for the SETTLE_CYCLES=3 instance.
    int run_len = 0, run_viol = 0, runs_seen = 0;
    logic prev_busy1 = 1'b0;
    logic [10:0] prev_vec1 = '0;
    always @(negedge clk) begin
        if (busy_v[1]) begin
            if (!prev_busy1) run_len = 1;
            else if ({a1, b1, s1} == prev_vec1) run_len++;
            else begin
                if (run_len != 4) run_viol++;
                runs_seen++;
                run_len = 1;
            end
        end
        prev_busy1 = busy_v[1];
        prev_vec1  = {a1, b1, s1};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
            $display("chk %-22s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int idx);
        @(negedge clk) start_v[idx] = 1'b1;
        @(negedge clk) start_v[idx] = 1'b0;
    endtask

    // Counts negedges after the start pulse until done; n equals clock edges from the accepting edge.
    task automatic wait_done(input int idx, input int exp_n, input int pulse_at, input string tag);
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            start_v[idx] = (pulse_at > 0 && n == pulse_at);
            if (done_v[idx] || n > 20000) break;
        end
        start_v[idx] = 1'b0;
        check(tag, n, exp_n);
    endtask

    task automatic check_result(input int idx, input string tag, input int pass_e,
                                input int err_e, input int fv_e);
        check({tag, "_pass"}, 32'(pass_v[idx]), pass_e);
        check({tag, "_err"},  err_v[idx], err_e);
        check({tag, "_fvec"}, 32'(fvec_v[idx]), fv_e);
        check({tag, "_busy"}, 32'(busy_v[idx]), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_v), 0);
        check("rst_done", 32'(done_v), 0);
        check("rst_vec0", 32'({a0, b0, s0}), 0);
        rst = 1'b0;

        // Reset mid-sweep with a faulty ALU so there is state to lose.
        fault0 = 1;
        pulse_start(0);
        repeat (100) @(negedge clk);
        check("pre_rst_busy", 32'(busy_v[0]), 1);
        check("pre_rst_err_nz", 32'(err_v[0] != 0), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy_v[0]), 0);
        check("midrst_done", 32'(done_v[0]), 0);
        check("midrst_err", err_v[0], 0);
        check("midrst_fvec", 32'(fvec_v[0]), 0);
        check("midrst_vec", 32'({a0, b0, s0}), 0);
        @(negedge clk) rst = 1'b0;

        // Good ALU, default settle: 2048 vectors * 2 cycles.
        fault0 = 0;
        pulse_start(0);
        check("good_busy", 32'(busy_v[0]), 1);
        wait_done(0, 4096, 0, "good_latency");
        check_result(0, "good", 1, 0, 0);

        // SUB returns a+b: mismatch whenever b != 0 -> 16*15 errors, first at {a=0,b=1,sel=1}.
        fault0 = 1;
        pulse_start(0);
        wait_done(0, 4096, 10, "sub_latency");
        check_result(0, "sub", 0, 240, {4'd0, 4'd1, 3'd1});
        check("sub_done_held", 32'(done_v[0]), 1);

        // Restart from DONE clears results on entry, then reproduces them.
        pulse_start(0);
        check("rerun_done_clr", 32'(done_v[0]), 0);
        check("rerun_err_clr", err_v[0], 0);
        check("rerun_pass_clr", 32'(pass_v[0]), 0);
        wait_done(0, 4096, 0, "rerun_latency");
        check_result(0, "rerun", 0, 240, {4'd0, 4'd1, 3'd1});

        // Settle window of 3: 4 cycles per vector.
        pulse_start(1);
        wait_done(1, 8192, 0, "settle3_latency");
        check_result(1, "settle3", 1, 0, 0);
        check("settle3_hold_viol", run_viol, 0);
        check("settle3_runs", runs_seen, 2047);

        // Stuck-at-0 output, 4-bit counter: ADD/SUB/AND/OR/XOR of 0,0 all give 0, NOT gives 15.
        pulse_start(2);
        wait_done(2, 4096, 0, "stuck_latency");
        check_result(2, "stuck", 0, 15, {4'd0, 4'd0, 3'd5});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
